cordic_sched: RTL

- Scheduler and arbiter that shares the single fully pipelined CORDIC cosine datapath between two requesters.
  - Port A: Nios II multi-cycle custom-instruction port.
  - Port B: streaming valid/ready port, e.g. a DMA feeder.
- Issues at most one operation per cycle and tags each in-flight operation so its result returns to the right requester.
- Owns the iteration-count register `n`. The datapath applies `n` to all stages at once, so the scheduler drains the pipeline before any `n` change takes effect.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_tag_pipe.sv | 50 +++++
 rtl/cordic_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC cosine scheduler.
//   CORDIC_LATENCY : clock edges from a theta update to the matching result
//                    (1 input stage + 32 iteration stages + 1 output stage)
//   req_id_e       : which requester an in-flight operation belongs to
//   sched_state_e  : scheduler FSM states
package cordic_pkg;

  localparam int CORDIC_LATENCY = 34;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_e;

endpackage

// File: rtl/cordic_tag_pipe.sv
// LATENCY-deep shift register of {valid, id} tags that tracks each
// operation through the CORDIC datapath, plus a count of tags in flight.
//   clk, reset : clock, asynchronous active-low reset (clears valid bits/count)
//   in_vld     : an operation is issued this cycle
//   in_id      : requester of the issued operation
//   out_vld    : final-stage tag is valid
//   out_id     : requester of the final-stage tag
//   inflight   : number of valid tags currently in the shift register
module cordic_tag_pipe
  import cordic_pkg::*;
#(
  parameter int LATENCY = CORDIC_LATENCY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_vld,
  input  req_id_e                        in_id,
  output logic                           out_vld,
  output req_id_e                        out_id,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-1:0] id_sr;

  assign out_vld = vld_sr[LATENCY-1];
  assign out_id  = req_id_e'(id_sr[LATENCY-1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      vld_sr <= {vld_sr[LATENCY-2:0], in_vld};
      // Issue and return on the same edge cancel out.
      if (in_vld && !out_vld)
        inflight <= inflight + CW'(1);
      else if (!in_vld && out_vld)
        inflight <= inflight - CW'(1);
    end
  end

  // Ids are only meaningful alongside a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    id_sr <= {id_sr[LATENCY-2:0], in_id};
  end

endmodule

// File: rtl/cordic_sched.sv
// Scheduler/arbiter sharing one pipelined CORDIC cosine datapath between
// a custom-instruction port (A) and a streaming valid/ready port (B).
// Owns the iteration count n and drains the datapath before changing it.
//   clk, reset              : clock, asynchronous active-low reset
//   a_start, a_dataa        : A request strobe and theta
//   a_done, a_result        : A result strobe and cosine
//   b_in_valid, b_in_data   : B request and theta
//   b_in_ready              : B request accepted this cycle (combinational)
//   b_out_valid, b_out_data : B result strobe and cosine
//   cfg_wr, cfg_n           : write strobe and value for n
//   cfg_busy                : draining / n update pending
//   cordic_theta, cordic_n  : datapath operand and iteration count
//   cordic_result           : datapath result
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int         LATENCY = CORDIC_LATENCY,
  parameter logic [4:0] N_RESET = 5'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_start,
  input  logic [31:0] a_dataa,
  output logic        a_done,
  output logic [31:0] a_result,
  input  logic        b_in_valid,
  input  logic [31:0] b_in_data,
  output logic        b_in_ready,
  output logic        b_out_valid,
  output logic [31:0] b_out_data,
  input  logic        cfg_wr,
  input  logic [4:0]  cfg_n,
  output logic        cfg_busy,
  output logic [31:0] cordic_theta,
  output logic [4:0]  cordic_n,
  input  logic [31:0] cordic_result
);

  sched_state_e state;
  req_id_e      rr_ptr;
  logic         a_pend, a_issued;
  logic [31:0]  a_theta;
  logic [4:0]   n_reg, n_shadow;
  logic         elig_a, elig_b, can_issue, grant_a, grant_b, issue;
  logic         tp_vld;
  req_id_e      tp_id;
  logic [$clog2(LATENCY+1)-1:0] inflight;
  logic         ret_vld_p0;
  req_id_e      ret_id_p0;

  assign cordic_n = n_reg;

  // Arbitration: a cfg write blocks grants in its own cycle as well.
  assign elig_a    = a_pend && !a_issued;
  assign elig_b    = b_in_valid;
  assign can_issue = (state == RUN) && !cfg_wr;
  assign grant_a   = can_issue && elig_a && (!elig_b || rr_ptr == ID_A);
  assign grant_b   = can_issue && elig_b && (!elig_a || rr_ptr == ID_B);
  assign issue     = grant_a || grant_b;
  // Gated by reset so the port reads 0 while reset is held.
  assign b_in_ready = grant_b && reset;

  cordic_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (issue),
    .in_id    (grant_b ? ID_B : ID_A),
    .out_vld  (tp_vld),
    .out_id   (tp_id),
    .inflight (inflight)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      rr_ptr       <= ID_A;
      a_pend       <= 1'b0;
      a_issued     <= 1'b0;
      n_reg        <= N_RESET;
      cfg_busy     <= 1'b0;
      cordic_theta <= '0;
      ret_vld_p0   <= 1'b0;
      ret_id_p0    <= ID_A;
      a_done       <= 1'b0;
      a_result     <= '0;
      b_out_valid  <= 1'b0;
      b_out_data   <= '0;
    end else begin
      // Issue stage: operand to the datapath.
      if (issue)
        cordic_theta <= grant_a ? a_theta : b_in_data;
      if (elig_a && elig_b && issue)
        rr_ptr <= grant_a ? ID_B : ID_A;

      // Return stage: the tag leaves the pipe one edge before the
      // datapath result is captured.
      ret_vld_p0  <= tp_vld;
      ret_id_p0   <= tp_id;
      a_done      <= ret_vld_p0 && (ret_id_p0 == ID_A);
      b_out_valid <= ret_vld_p0 && (ret_id_p0 == ID_B);
      if (ret_vld_p0 && ret_id_p0 == ID_A)
        a_result <= cordic_result;
      if (ret_vld_p0 && ret_id_p0 == ID_B)
        b_out_data <= cordic_result;

      // A request bookkeeping; starts while pending are ignored.
      if (ret_vld_p0 && ret_id_p0 == ID_A) begin
        a_pend   <= 1'b0;
        a_issued <= 1'b0;
      end else begin
        if (!a_pend && a_start)
          a_pend <= 1'b1;
        if (grant_a)
          a_issued <= 1'b1;
      end

      unique case (state)
        RUN: begin
          if (cfg_wr) begin
            state    <= DRAIN;
            cfg_busy <= 1'b1;
          end
        end
        DRAIN: begin
          // A fresh write restarts the check so the latest value lands.
          if (!cfg_wr && inflight == '0 && !ret_vld_p0) begin
            n_reg    <= n_shadow;
            cfg_busy <= 1'b0;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Operand holding registers carry data only.
  always_ff @(posedge clk) begin
    if (cfg_wr)
      n_shadow <= cfg_n;
    if (!a_pend && a_start)
      a_theta <= a_dataa;
  end

endmodule
